// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte handshake between the dump sequencer and the UART transmitter
// Ports: in_data/in_valid driven by the sequencer (master), in_ready returned by the FIFO (slave).
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter with host hold
// Ports: clk12m/reset (sync, active-high); in_if byte handshake (slave);
//        hold blocks new frame starts; tx UART line (idle high);
//        busy = frame on line or FIFO non-empty; level = FIFO occupancy.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 12,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk12m,
  input  logic                          reset,
  uart_tx_fifo_if.slave                 in_if,
  input  logic                          hold,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, in_ready_d;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          push, pop, start_ok, baud_done;

  // Frame sequencing: bit_cnt counts data bits in DATA and stop bits in STOP.
  always_comb begin
    push       = in_if.in_valid && in_ready_q;
    start_ok   = (level_q != '0) && !hold;
    baud_done  = (baud_cnt_q == BAUD_LAST);
    pop        = 1'b0;
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          state_d    = START;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            // Back-to-back frames: the next start bit follows the last stop cycle directly.
            if (start_ok) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; in_ready is registered from the next level so a pop
  // on a full FIFO cannot admit a push on the same edge.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    in_ready_d = (level_d != LEVEL_FULL);
  end

  // Line and busy are registered from the current state, so tx lags the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || (level_q != '0);
  end

  always_ff @(posedge clk12m) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk12m) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= in_if.in_data;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign level          = level_q;

endmodule
